nonce_tx_arbiter: RTL and testbench

- Shares the single serial_transmit UART instance between NUM_CORES scrypt hasher cores, returning golden nonces to the host.
- Each core gets a one-entry holding register; a round-robin scheduler picks a pending nonce and drives the send/busy/word handshake of serial_transmit.
- Sits in ltcminer_icarus between the hasher cores and the TxD serial_transmit; new_work comes from the getwork receive path.

---
 rtl/nonce_tx_arbiter_pkg.sv | 17 +
 rtl/nonce_tx_arbiter_rr.sv | 34 +++
 rtl/nonce_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_nonce_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_tx_arbiter_pkg.sv
// rtl/nonce_tx_arbiter_pkg.sv - shared state encodings, timeout default and byte-swap helper
package nonce_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

  localparam int unsigned DEFAULT_BUSY_TIMEOUT = 15;

  // Reverse byte order so the host receives the nonce little-endian.
  function automatic logic [31:0] swap_bytes32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nonce_tx_arbiter_rr.sv
// rtl/nonce_tx_arbiter_rr.sv - round-robin arbiter: request vector plus last-grant pointer to one-hot grant and index
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned cand;

  // Scan from ptr+1 around the ring; the first requester found wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!valid_o && req_i[IDXW'(cand)]) begin
        valid_o             = 1'b1;
        idx_o               = IDXW'(cand);
        gnt_o[IDXW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_tx_arbiter.sv
// rtl/nonce_tx_arbiter.sv - shares one serial transmitter between hasher cores returning golden nonces
module nonce_tx_arbiter
  import nonce_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
  parameter bit          SWAP_BYTES   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    nonce_valid,
  input  logic [32*NUM_CORES-1:0] nonce_in,
  input  logic                    new_work,
  input  logic                    tx_busy,
  output logic                    tx_send,
  output logic [31:0]             tx_word,
  output logic [NUM_CORES-1:0]    pending,
  output logic                    tx_active,
  output logic [7:0]              drop_count
);

  localparam int unsigned     IDXW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDXW-1:0] RR_RESET    = IDXW'(NUM_CORES - 1);
  localparam logic [4:0]      TIMEOUT_LIM = 5'(BUSY_TIMEOUT);

  tx_state_e            state_q, state_d;
  logic [IDXW-1:0]      rr_q, rr_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [31:0]          hold_q [NUM_CORES];
  logic [31:0]          tx_word_q, tx_word_d;
  logic                 tx_send_q, tx_send_d;
  logic [3:0]           timer_q, timer_d;
  logic [7:0]           drop_q, drop_d;
  logic [8:0]           drop_inc, drop_sum;

  logic [NUM_CORES-1:0] arb_gnt, gnt_eff;
  logic [IDXW-1:0]      arb_idx;
  logic                 arb_any, grant_en, timeout_drop;

  rr_arbiter #(.N(NUM_CORES), .IDXW(IDXW)) u_rr (
    .req_i   (pending_q),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_any)
  );

  // A fresh getwork blocks granting so stale nonces never reach the host.
  assign grant_en = (state_q == ST_IDLE) && arb_any && !new_work;
  assign gnt_eff  = grant_en ? arb_gnt : '0;

  // Transmit handshake: grant from IDLE, wait for busy to rise, then to fall.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    tx_word_d    = tx_word_q;
    tx_send_d    = 1'b0;
    timer_d      = timer_q;
    timeout_drop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          state_d   = ST_WAIT_BUSY;
          rr_d      = arb_idx;
          tx_word_d = SWAP_BYTES ? swap_bytes32(hold_q[arb_idx]) : hold_q[arb_idx];
          tx_send_d = 1'b1;
          timer_d   = 4'd0;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (({1'b0, timer_q} + 5'd1) >= TIMEOUT_LIM) begin
          state_d      = ST_IDLE;
          timeout_drop = 1'b1;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding-register occupancy and lost-nonce accounting.
  always_comb begin
    pending_d = pending_q;
    drop_inc  = 9'(timeout_drop);
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (new_work) begin
        pending_d[i] = 1'b0;
      end else if (nonce_valid[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i] && !gnt_eff[i]) begin
          drop_inc = drop_inc + 9'd1;
        end
      end else if (gnt_eff[i]) begin
        pending_d[i] = 1'b0;
      end
    end
    drop_sum = {1'b0, drop_q} + drop_inc;
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: pointer, word, strobe, timer, counters, occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= RR_RESET;
      tx_word_q <= '0;
      tx_send_q <= 1'b0;
      timer_q   <= '0;
      drop_q    <= '0;
      pending_q <= '0;
    end else begin
      rr_q      <= rr_d;
      tx_word_q <= tx_word_d;
      tx_send_q <= tx_send_d;
      timer_q   <= timer_d;
      drop_q    <= drop_d;
      pending_q <= pending_d;
    end
  end

  // Per-core holding registers; a granted core's old value was already copied out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (nonce_valid[i] && !new_work) begin
          hold_q[i] <= nonce_in[32*i +: 32];
        end
      end
    end
  end

  assign tx_send    = tx_send_q;
  assign tx_word    = tx_word_q;
  assign pending    = pending_q;
  assign tx_active  = (state_q != ST_IDLE);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// tb/tb_nonce_tx_arbiter.sv - directed self-checking bench for nonce_tx_arbiter
module tb_nonce_tx_arbiter;

  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NC-1:0]   nonce_valid = '0;
  logic [32*NC-1:0] nonce_in = '0;
  logic            new_work = 1'b0;
  logic            tx_busy = 1'b0;
  logic            tx_send, sw_tx_send;
  logic [31:0]     tx_word, sw_tx_word;
  logic [NC-1:0]   pending, sw_pending;
  logic            tx_active, sw_tx_active;
  logic [7:0]      drop_count, sw_drop_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_left = 0;
  bit busy_en = 1'b1;
  bit prev_send = 1'b0;
  logic [31:0] sent_q[$];
  int          send_cyc_q[$];

  nonce_tx_arbiter #(.NUM_CORES(NC), .BUSY_TIMEOUT(15), .SWAP_BYTES(1'b0)) dut (
    .clk(clk), .reset(reset), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .new_work(new_work), .tx_busy(tx_busy), .tx_send(tx_send), .tx_word(tx_word),
    .pending(pending), .tx_active(tx_active), .drop_count(drop_count)
  );

  nonce_tx_arbiter #(.NUM_CORES(NC), .BUSY_TIMEOUT(15), .SWAP_BYTES(1'b1)) dut_sw (
    .clk(clk), .reset(reset), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .new_work(new_work), .tx_busy(tx_busy), .tx_send(sw_tx_send), .tx_word(sw_tx_word),
    .pending(sw_pending), .tx_active(sw_tx_active), .drop_count(sw_drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: busy rises the cycle after tx_send and stays high 10 cycles.
  always @(posedge clk) begin
    #1;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
    if (tx_send && busy_en) busy_left = 10;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Send monitor: log each word and police the strobe rules.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_send) begin
        check_eq("send_while_busy", 32'(tx_busy), 32'd0);
        check_eq("send_back_to_back", 32'(prev_send), 32'd0);
        sent_q.push_back(tx_word);
        send_cyc_q.push_back(cyc);
      end
      prev_send = tx_send;
    end else begin
      prev_send = 1'b0;
    end
  end

  function automatic logic [31:0] sent_word(input int i);
    if (i < sent_q.size()) return sent_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int sent_cyc(input int i);
    if (i < send_cyc_q.size()) return send_cyc_q[i];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    nonce_valid = '0;
    new_work = 1'b0;
  endtask

  task automatic set_nonce(input int core, input logic [31:0] w);
    nonce_valid[core] = 1'b1;
    nonce_in[32*core +: 32] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sent_q.delete();
    send_cyc_q.delete();
  endtask

  task automatic wait_sends(input int n, input int budget, input string tag);
    int i = 0;
    while (sent_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(sent_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (tx_active && i < budget) begin
      tick();
      i++;
    end
  endtask

  initial begin
    int t0;
    do_reset();
    check_eq("rst_tx_send", 32'(tx_send), 32'd0);
    check_eq("rst_tx_word", tx_word, 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_tx_active", 32'(tx_active), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);

    // Single nonce, minimum latency, byte swap
    set_nonce(0, 32'h0000318f);
    t0 = cyc;
    tick();
    wait_sends(1, 20, "single_count");
    check_eq("single_cycle", 32'(sent_cyc(0)), 32'(t0 + 2));
    check_eq("single_word", sent_word(0), 32'h0000318f);
    check_eq("single_word_swapped", sw_tx_word, 32'h8f310000);
    wait_idle(40);
    check_eq("single_idle", 32'(tx_active), 32'd0);
    repeat (5) tick();
    check_eq("single_only_one", 32'(sent_q.size()), 32'd1);
    check_eq("single_drop", 32'(drop_count), 32'd0);

    // Round robin from reset pointer (3): A0,A1,A2,A3
    do_reset();
    for (int c = 0; c < NC; c++) set_nonce(c, 32'hA0 + 32'(c));
    tick();
    wait_sends(4, 200, "rr1_count");
    check_eq("rr1_w0", sent_word(0), 32'hA0);
    check_eq("rr1_w1", sent_word(1), 32'hA1);
    check_eq("rr1_w2", sent_word(2), 32'hA2);
    check_eq("rr1_w3", sent_word(3), 32'hA3);
    wait_idle(40);

    // Round robin with pointer at 1: 51 first, then A2,A3,A0,A1
    do_reset();
    set_nonce(1, 32'h51);
    tick();
    tick();
    for (int c = 0; c < NC; c++) set_nonce(c, 32'hA0 + 32'(c));
    tick();
    wait_sends(5, 200, "rr2_count");
    check_eq("rr2_w0", sent_word(0), 32'h51);
    check_eq("rr2_w1", sent_word(1), 32'hA2);
    check_eq("rr2_w2", sent_word(2), 32'hA3);
    check_eq("rr2_w3", sent_word(3), 32'hA0);
    check_eq("rr2_w4", sent_word(4), 32'hA1);
    check_eq("rr2_drop", 32'(drop_count), 32'd0);
    wait_idle(40);

    // Overwrite of core2 while core0 transmits
    do_reset();
    set_nonce(0, 32'hC0);
    tick(); tick(); tick();
    set_nonce(2, 32'h11);
    tick(); tick();
    set_nonce(2, 32'h22);
    tick();
    check_eq("ovw_drop", 32'(drop_count), 32'd1);
    wait_sends(2, 60, "ovw_count");
    check_eq("ovw_w0", sent_word(0), 32'hC0);
    check_eq("ovw_w1", sent_word(1), 32'h22);
    wait_idle(40);
    repeat (20) tick();
    check_eq("ovw_total", 32'(sent_q.size()), 32'd2);

    // new_work during a core3 transmission
    do_reset();
    set_nonce(3, 32'h33);
    tick(); tick();
    set_nonce(0, 32'h55);
    tick(); tick();
    check_eq("nw_pending_before", 32'(pending), 32'h1);
    set_nonce(1, 32'h44);
    new_work = 1'b1;
    tick();
    check_eq("nw_pending_after", 32'(pending), 32'h0);
    check_eq("nw_drop", 32'(drop_count), 32'd0);
    wait_idle(40);
    repeat (20) tick();
    check_eq("nw_total", 32'(sent_q.size()), 32'd1);
    check_eq("nw_word", sent_word(0), 32'h33);

    // Busy never rises: timeout, drop, next nonce granted
    do_reset();
    busy_en = 1'b0;
    set_nonce(0, 32'h66);
    set_nonce(1, 32'h77);
    t0 = cyc;
    tick();
    repeat (16) tick();
    check_eq("to_idle", 32'(tx_active), 32'd0);
    check_eq("to_drop1", 32'(drop_count), 32'd1);
    wait_sends(2, 10, "to_count");
    check_eq("to_cycle0", 32'(sent_cyc(0)), 32'(t0 + 2));
    check_eq("to_cycle1", 32'(sent_cyc(1)), 32'(t0 + 18));
    check_eq("to_w1", sent_word(1), 32'h77);
    wait_idle(40);
    check_eq("to_drop2", 32'(drop_count), 32'd2);
    busy_en = 1'b1;

    // Async reset in WAIT_DONE with two nonces pending
    do_reset();
    set_nonce(0, 32'h81);
    tick(); tick();
    set_nonce(1, 32'h82);
    set_nonce(2, 32'h83);
    tick(); tick(); tick();
    check_eq("ar_pending_before", 32'(pending), 32'h6);
    check_eq("ar_active_before", 32'(tx_active), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_tx_send", 32'(tx_send), 32'd0);
    check_eq("ar_tx_word", tx_word, 32'd0);
    check_eq("ar_pending", 32'(pending), 32'd0);
    check_eq("ar_active", 32'(tx_active), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sent_q.delete();
    send_cyc_q.delete();
    repeat (30) tick();
    check_eq("ar_quiet", 32'(sent_q.size()), 32'd0);
    set_nonce(2, 32'h99);
    tick();
    wait_sends(1, 20, "ar_new_count");
    check_eq("ar_new_word", sent_word(0), 32'h99);
    wait_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
